// File: rtl/memory_responder_pkg.sv
// Shared bus typedefs plus the responder's FSM state, request latch and control record.
package memory_responder_pkg;

    typedef logic [31:0] bus_addr_t;
    typedef logic [31:0] bus_data_t;
    typedef logic [3:0]  bus_strb_t;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic      instr;
        bus_addr_t addr;
        bus_data_t wdata;
        bus_strb_t wstrb;
    } req_latch_t;

    // Whole registered control record; ready/error/rd_ok are the registered output flags.
    typedef struct packed {
        resp_state_t       state;
        logic [CNT_W-1:0]  count;
        req_latch_t        req;
        logic              bad;
        logic              ready;
        logic              error;
        logic              rd_ok;
    } ctrl_t;

    function automatic logic is_write(input bus_strb_t strb);
        return |strb;
    endfunction

endpackage

// File: rtl/memory_responder_sram_array.sv
// Single-port-per-direction word RAM: registered read, independent byte-lane writes.
module sram_array
    import memory_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic [DEPTH_LOG2-1:0] read_addr,
    output bus_data_t             read_data,
    input  logic                  write_en,
    input  logic [DEPTH_LOG2-1:0] write_addr,
    input  bus_data_t             write_data,
    input  bus_strb_t             write_strb
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (write_en && write_strb[gi]) begin
                    lane_mem[write_addr] <= write_data[8*gi +: 8];
                end
                rd_byte_reg <= lane_mem[read_addr];
            end

            assign read_data[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

endmodule

// File: rtl/memory_responder.sv
// Memory-bus responder: accepts one request at a time and completes it LATENCY cycles later
// with a one-cycle ready pulse, backed by an on-chip word RAM.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic        memory_error
);

    localparam logic [32:0] SPAN = 33'd4 << DEPTH_LOG2;

    ctrl_t                 ctrl_reg;
    ctrl_t                 ctrl_next;
    bus_addr_t             offset_in;
    bus_addr_t             offset_lat;
    logic [DEPTH_LOG2-1:0] idx_in;
    logic [DEPTH_LOG2-1:0] idx_lat;
    logic [DEPTH_LOG2-1:0] ram_raddr;
    bus_data_t             ram_rdata;
    logic                  ram_we;
    logic                  bad_in;
    logic                  unused_ctrl;

    assign offset_in  = memory_addr - BASE_ADDR;
    assign offset_lat = ctrl_reg.req.addr - BASE_ADDR;
    assign idx_in     = offset_in[DEPTH_LOG2+1:2];
    assign idx_lat    = offset_lat[DEPTH_LOG2+1:2];
    assign bad_in     = ({1'b0, offset_in} >= SPAN) || (memory_instr && is_write(memory_wstrb));

    assign unused_ctrl = ^{ctrl_reg.req.instr, offset_lat[1:0], offset_lat[31:DEPTH_LOG2+2]};

    // The RAM read port follows the incoming address while idle so a LATENCY=1 read has its
    // data registered at the acceptance edge; otherwise it keeps re-reading the latched word.
    assign ram_raddr = (ctrl_reg.state == IDLE) ? idx_in : idx_lat;
    assign ram_we    = reset && (ctrl_reg.state == RESP) && is_write(ctrl_reg.req.wstrb)
                       && !ctrl_reg.bad;

    always_comb begin
        ctrl_next       = ctrl_reg;
        ctrl_next.ready = 1'b0;
        ctrl_next.error = 1'b0;
        ctrl_next.rd_ok = 1'b0;
        case (ctrl_reg.state)
            IDLE: begin
                if (memory_valid) begin
                    ctrl_next.req.instr = memory_instr;
                    ctrl_next.req.addr  = memory_addr;
                    ctrl_next.req.wdata = memory_wdata;
                    ctrl_next.req.wstrb = memory_wstrb;
                    ctrl_next.bad       = bad_in;
                    if (LATENCY == 1) begin
                        ctrl_next.state = RESP;
                        ctrl_next.count = '0;
                    end else begin
                        ctrl_next.state = WAIT;
                        ctrl_next.count = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (ctrl_reg.count == CNT_W'(1)) begin
                    ctrl_next.state = RESP;
                    ctrl_next.count = '0;
                end else begin
                    ctrl_next.count = ctrl_reg.count - CNT_W'(1);
                end
            end
            RESP: begin
                ctrl_next.state = IDLE;
            end
            default: begin
                ctrl_next.state = IDLE;
            end
        endcase
        if (ctrl_next.state == RESP) begin
            ctrl_next.ready = 1'b1;
            ctrl_next.error = ctrl_next.bad;
            ctrl_next.rd_ok = !ctrl_next.bad && !is_write(ctrl_next.req.wstrb);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ctrl_reg <= '0;
        end else begin
            ctrl_reg <= ctrl_next;
        end
    end

    sram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_sram (
        .clock      (clock),
        .read_addr  (ram_raddr),
        .read_data  (ram_rdata),
        .write_en   (ram_we),
        .write_addr (idx_lat),
        .write_data (ctrl_reg.req.wdata),
        .write_strb (ctrl_reg.req.wstrb)
    );

    assign memory_ready = ctrl_reg.ready;
    assign memory_error = ctrl_reg.error;
    assign memory_rdata = ctrl_reg.rd_ok ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_memory_responder.sv
// Two responders (LATENCY 1 and 4) driven by directed and random requests, checked every
// cycle against a transaction-level model of the responder.
module tb_memory_responder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset [2];
    logic        valid [2];
    logic        instr [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        error [2];

    int checks = 0;
    int passed = 0;

    memory_responder #(.DEPTH_LOG2(12), .LATENCY(1), .BASE_ADDR(32'h0)) dut_lat1 (
        .clock(clock), .reset(reset[0]), .memory_valid(valid[0]), .memory_instr(instr[0]),
        .memory_addr(addr[0]), .memory_wdata(wdata[0]), .memory_wstrb(wstrb[0]),
        .memory_rdata(rdata[0]), .memory_ready(ready[0]), .memory_error(error[0]));

    memory_responder #(.DEPTH_LOG2(12), .LATENCY(4), .BASE_ADDR(32'h0)) dut_lat4 (
        .clock(clock), .reset(reset[1]), .memory_valid(valid[1]), .memory_instr(instr[1]),
        .memory_addr(addr[1]), .memory_wdata(wdata[1]), .memory_wstrb(wstrb[1]),
        .memory_rdata(rdata[1]), .memory_ready(ready[1]), .memory_error(error[1]));

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Transaction model: one outstanding request per responder, word memory keyed by inst/word.
    logic [31:0] model_mem [int];
    bit          m_pend  [2];
    int          m_age   [2];
    bit          m_err   [2];
    bit          m_read  [2];
    bit          m_known [2];
    int          m_key   [2];
    logic [31:0] m_val   [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];

    task automatic model_step(input int i);
        bit          exp_ready;
        bit          exp_error;
        logic [31:0] exp_rdata;
        bit          data_ok;
        bit          was_idle;
        logic [31:0] off;
        logic [31:0] w;
        exp_ready = m_pend[i] && (m_age[i] == lat_of(i));
        exp_error = exp_ready && m_err[i];
        exp_rdata = (exp_ready && !m_err[i] && m_read[i]) ? m_val[i] : 32'h0;
        data_ok   = (rdata[i] === exp_rdata) ||
                    (exp_ready && !m_err[i] && m_read[i] && !m_known[i]);
        checks++;
        if (ready[i] === exp_ready && error[i] === exp_error && data_ok) begin
            passed++;
        end else begin
            $display("FAIL cycle_model inst%0d t=%0t ready=%b want %b error=%b want %b rdata=%h want %h",
                     i, $time, ready[i], exp_ready, error[i], exp_error, rdata[i], exp_rdata);
        end
        was_idle = !m_pend[i];
        if (!reset[i]) begin
            m_pend[i] = 1'b0;
        end else if (m_pend[i]) begin
            if (m_age[i] == lat_of(i)) begin
                if (!m_read[i] && !m_err[i]) begin
                    w = model_mem.exists(m_key[i]) ? model_mem[m_key[i]] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[i][b]) w[8*b +: 8] = m_wdata[i][8*b +: 8];
                    model_mem[m_key[i]] = w;
                end
                m_pend[i] = 1'b0;
            end else begin
                m_age[i]++;
            end
        end
        if (reset[i] && was_idle && valid[i]) begin
            off        = addr[i];
            m_err[i]   = (off >= 32'h4000) || (instr[i] && wstrb[i] != 4'h0);
            m_read[i]  = (wstrb[i] == 4'h0);
            m_key[i]   = i * 65536 + int'(off[13:2]);
            m_known[i] = model_mem.exists(m_key[i]);
            m_val[i]   = m_known[i] ? model_mem[m_key[i]] : 32'h0;
            m_wdata[i] = wdata[i];
            m_wstrb[i] = wstrb[i];
            m_pend[i]  = 1'b1;
            m_age[i]   = 1;
        end
    endtask

    always begin
        @(negedge clock);
        #2;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h required %h", name, got, want);
    endtask

    // Presents a request now and returns on the negedge+1 of its ready cycle, inputs still held.
    task automatic issue(input int i, input bit ins, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int drop_after,
                         output logic [31:0] got_data, output bit got_err, output int waited);
        valid[i] = 1'b1; instr[i] = ins; addr[i] = a; wdata[i] = d; wstrb[i] = s;
        waited = 0; got_data = 32'h0; got_err = 1'b0;
        while (1) begin
            @(negedge clock);
            #1;
            waited++;
            if (ready[i] === 1'b1) begin
                got_data = rdata[i];
                got_err  = error[i];
                break;
            end
            if (drop_after > 0 && waited == drop_after) valid[i] = 1'b0;
            if (waited >= 40) begin
                checks++;
                $display("FAIL ready_timeout inst%0d addr=%h: got no ready required ready within 40 cycles", i, a);
                break;
            end
        end
    endtask

    task automatic gap(input int i, input int n);
        valid[i] = 1'b0;
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit          e;
        int          w;
        int          pulses;
        int          i;
        int          sel;
        logic [31:0] a;
        logic [3:0]  s;
        bit          ins;
        int          drop;

        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b0; valid[k] = 1'b0; instr[k] = 1'b0;
            addr[k] = 32'h0; wdata[k] = 32'h0; wstrb[k] = 4'h0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        check_eq("reset_outputs_lat1", {rdata[0][30:0], ready[0]} | {31'h0, error[0]}, 32'h0);
        check_eq("reset_outputs_lat4", {rdata[1][30:0], ready[1]} | {31'h0, error[1]}, 32'h0);

        // LATENCY=1 full write / read-back
        gap(0, 1);
        issue(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 0, d, e, w);
        check_eq("wr10_error", {31'h0, e}, 32'h0);
        check_eq("wr10_latency", w, 32'd1);
        gap(0, 1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, d, e, w);
        check_eq("rd10_data", d, 32'hDEADBEEF);
        check_eq("rd10_latency", w, 32'd1);

        // Byte write, issued back-to-back (next request presented in the ready cycle)
        issue(0, 1'b0, 32'h20, 32'h11223344, 4'hF, 0, d, e, w);
        issue(0, 1'b0, 32'h20, 32'h000000AA, 4'b0001, 0, d, e, w);
        check_eq("b2b_second_ready_wait", w, 32'd2);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, d, e, w);
        check_eq("byte_write_merge", d, 32'h112233AA);

        // Out-of-range accesses
        issue(0, 1'b0, 32'h0, 32'hCAFEF00D, 4'hF, 0, d, e, w);
        issue(0, 1'b0, 32'h4000, 32'h0, 4'h0, 0, d, e, w);
        check_eq("oor_read_error", {31'h0, e}, 32'h1);
        check_eq("oor_read_data", d, 32'h0);
        issue(0, 1'b0, 32'h4000, 32'h12345678, 4'hF, 0, d, e, w);
        check_eq("oor_write_error", {31'h0, e}, 32'h1);
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, d, e, w);
        check_eq("word0_unchanged", d, 32'hCAFEF00D);

        // Instruction fetch: write is an error, read is normal
        issue(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 0, d, e, w);
        check_eq("ifetch_write_error", {31'h0, e}, 32'h1);
        issue(0, 1'b1, 32'h13, 32'h0, 4'h0, 0, d, e, w);
        check_eq("ifetch_read_data", d, 32'hDEADBEEF);
        check_eq("ifetch_read_error", {31'h0, e}, 32'h0);
        gap(0, 1);

        // LATENCY=4, valid dropped while waiting
        gap(1, 1);
        issue(1, 1'b0, 32'h10, 32'h0BADF00D, 4'hF, 0, d, e, w);
        check_eq("lat4_write_latency", w, 32'd4);
        gap(1, 1);
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 2, d, e, w);
        check_eq("lat4_read_latency", w, 32'd4);
        check_eq("lat4_read_data", d, 32'h0BADF00D);

        // Reset while a write waits: no pulse, RAM untouched
        issue(1, 1'b0, 32'h30, 32'h55555555, 4'hF, 0, d, e, w);
        gap(1, 1);
        valid[1] = 1'b1; instr[1] = 1'b0; addr[1] = 32'h30; wdata[1] = 32'hAAAAAAAA; wstrb[1] = 4'hF;
        pulses = 0;
        repeat (2) begin
            @(negedge clock);
            #1;
            if (ready[1] === 1'b1) pulses++;
        end
        reset[1] = 1'b0;
        valid[1] = 1'b0;
        @(negedge clock);
        #1;
        reset[1] = 1'b1;
        repeat (6) begin
            @(negedge clock);
            #1;
            if (ready[1] === 1'b1) pulses++;
        end
        check_eq("reset_wait_no_pulse", pulses, 32'd0);
        issue(1, 1'b0, 32'h30, 32'h0, 4'h0, 0, d, e, w);
        check_eq("reset_wait_word_kept", d, 32'h55555555);
        gap(1, 1);

        // Random traffic on a 16-word window, pre-initialised in both responders
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 16; j++)
                issue(k, 1'b0, 32'h100 + 32'(j * 4), $urandom, 4'hF, 0, d, e, w);
            gap(k, 1);
        end
        for (int n = 0; n < 240; n++) begin
            i   = (n / 20) % 2;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = 32'h4000 + ($urandom_range(0, 255) << 2);
            else if (sel == 1) a = 32'hFFFFFFFC;
            else               a = 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            s    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ins  = ($urandom_range(0, 6) == 0);
            drop = (i == 0) ? 0 : int'($urandom_range(0, 1)) * int'($urandom_range(2, 3));
            issue(i, ins, a, $urandom, s, drop, d, e, w);
            if ($urandom_range(0, 3) == 0 || n % 20 == 19) gap(i, int'($urandom_range(1, 2)));
        end
        gap(0, 1);
        gap(1, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 12, log2 of RAM depth in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 1, cycles from request acceptance to memory_ready (legal range 1..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port memory_valid  input  1  request present; held by initiator until memory_ready.
REQ-007 SHALL have port memory_instr  input  1  request is an instruction fetch.
REQ-008 SHALL have port memory_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 SHALL have port memory_wdata  input  32  write data.
REQ-010 SHALL have port memory_wstrb  input  4  byte write enables; 4'b0000 means read.
REQ-011 SHALL have port memory_rdata  output  32  read data, valid only while memory_ready=1.
REQ-012 SHALL have port memory_ready  output  1  single-cycle completion pulse.
REQ-013 SHALL have port memory_error  output  1  completion is an error; qualified by memory_ready.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 IDLE with memory_valid=1 SHALL latch instr/addr/wdata/wstrb (acceptance cycle) and go to RESP if LATENCY=1, else to WAIT with counter loaded LATENCY-1.
REQ-016 WAIT SHALL decrement the counter each cycle and go to RESP when counter reaches 1 -> ready exactly LATENCY cycles after acceptance.
REQ-017 RESP SHALL assert memory_ready=1 for exactly one cycle, then return to IDLE.
REQ-018 memory_valid SHALL be ignored in WAIT and RESP; a request presented during RESP is accepted in the following IDLE cycle (initiator holds valid).
REQ-019 memory_valid dropping during WAIT SHALL NOT abort the latched request.
REQ-020 Word index SHALL be (addr - BASE_ADDR)[DEPTH_LOG2+1:2]; request in range iff 0 <= addr - BASE_ADDR < 4*2^DEPTH_LOG2 (unsigned, 32-bit).
REQ-021 Read (wstrb=0) in range SHALL return the addressed word on memory_rdata in the RESP cycle.
REQ-022 Write in range SHALL update only bytes with wstrb bit set, committed at the end of the RESP cycle; memory_rdata=0 for writes.
REQ-023 A read immediately following a write to the same word SHALL return the new data.
REQ-024 Out-of-range request, or memory_instr=1 with wstrb!=0, SHALL complete with memory_error=1, memory_rdata=0, no RAM update.
REQ-025 Outside RESP, memory_ready, memory_error, memory_rdata SHALL be 0.

Reset
REQ-026 reset=0 at a clock edge SHALL force IDLE, counter 0, latched request cleared; outputs 0 next cycle.
REQ-027 Reset during WAIT/RESP SHALL abort the request with no ready pulse and no RAM write; RAM contents SHALL NOT be cleared.

Structure
REQ-028 FSM state enum and the request-latch struct type SHALL reside in the shared package alongside existing bus typedefs.
REQ-029 RAM SHALL be a sub-module sram_array: synchronous read, per-byte write enable, 2^DEPTH_LOG2 x 32.
REQ-030 Control SHALL use the two-process style (combinational next-state record, registered state).

Verification
REQ-031 LATENCY=1: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> ready 1 cycle after acceptance, error=0; then read 0x10 -> rdata 0xDEADBEEF.
REQ-032 Byte write: word 0x20=0x11223344, write wdata 0x000000AA wstrb 4'b0001 -> read returns 0x112233AA.
REQ-033 LATENCY=4: read accepted cycle k -> ready only at k+4, ready=0 at k+1..k+3 and k+5; valid dropped at k+2 still completes.
REQ-034 DEPTH_LOG2=12, BASE_ADDR=0: read 0x4000 -> ready with error=1, rdata=0; write 0x4000 leaves word 0 unchanged.
REQ-035 Back-to-back: new request presented in RESP cycle, valid held -> accepted next cycle, two distinct ready pulses, no loss.
REQ-036 reset=0 in WAIT of a write -> no ready pulse, target word unchanged on later read.
